siso_seq_ctrl: RTL and testbench

Sequencing controller for the 4-stage SISO shift register chain. It accepts a parallel word over a valid/ready handshake and serializes it MSB-first onto the chain's serial input. It drives the chain's clock enable through the fill and flush phases, recaptures the word from the chain's serial output, and reports done with a loopback mismatch flag. It sits between a word-level producer and the bit-serial SISO datapath.

---
 rtl/siso_pkg.sv | 14 +
 rtl/siso_piso_tx.sv | 23 ++
 rtl/siso_seq_ctrl.sv | 113 +++++++++++
 tb/tb_siso_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared types and defaults for the SISO chain sequencer and its chain bench.
package siso_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/siso_piso_tx.sv
// Parallel-in serial-out transmit register: parallel load, left shift, MSB out.
module siso_piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] tx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        tx_reg <= '0;
    else if (load)  tx_reg <= data;
    else if (shift) tx_reg <= tx_reg << 1;
  end

  assign msb = tx_reg[WIDTH-1];

endmodule

// File: rtl/siso_seq_ctrl.sv
// Sequencer for a SISO shift chain: serializes a word MSB-first, flushes the
// chain, recaptures the word from the chain output and flags loopback mismatch.
module siso_seq_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             shift_en,
  output logic             din,
  input  logic             sout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             mismatch
);

  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] FIRST_CAP  = CW'(DEPTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cyc_cnt;
  logic [WIDTH-1:0] orig_reg;
  logic [WIDTH-1:0] rx_next;
  logic             tx_msb;
  logic             accept;
  logic             capture;

  assign accept  = (state == IDLE) && load_valid;
  assign capture = shift_en && (cyc_cnt >= FIRST_CAP);

  generate
    if (WIDTH == 1) begin : g_rx1
      assign rx_next = sout;
    end else begin : g_rxn
      assign rx_next = {rx_data[WIDTH-2:0], sout};
    end
  endgenerate

  siso_piso_tx #(.WIDTH(WIDTH)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state == SHIFT),
    .data  (load_data),
    .msb   (tx_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    shift_en   = 1'b0;
    din        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        din      = tx_msb;
        if (cyc_cnt == LAST_SHIFT) state_nx = FLUSH;
      end
      FLUSH: begin
        shift_en = 1'b1;
        busy     = 1'b1;
        if (cyc_cnt == LAST_FLUSH) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The last capture lands on the same edge that enters DONE, so the
  // mismatch compare uses the word as it will be after that capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      orig_reg <= '0;
      rx_data  <= '0;
      mismatch <= 1'b0;
    end else begin
      if (accept) begin
        orig_reg <= load_data;
        cyc_cnt  <= '0;
      end else if (shift_en) begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
      if (capture) rx_data <= rx_next;
      if (state == FLUSH && cyc_cnt == LAST_FLUSH)
        mismatch <= (rx_next != orig_reg);
    end
  end

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Self-checking bench: table-driven loopback vectors through a 4-stage chain
// model, scoreboard on done, plus back-to-back, abort and WIDTH=DEPTH=1 cases.
module tb_siso_seq_ctrl;
  import siso_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int D = DEF_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         load_valid = 1'b0;
  logic [W-1:0] load_data  = '0;
  logic         load_ready, shift_en, din, busy, done, mismatch, sout;
  logic [W-1:0] rx_data;

  logic [D-1:0] chain;
  logic         force0    = 1'b0;
  logic         chain_clr = 1'b1;
  assign sout = force0 ? 1'b0 : chain[D-1];

  always @(posedge clk or posedge chain_clr)
    if (chain_clr)     chain <= '0;
    else if (shift_en) chain <= {chain[D-2:0], din};

  siso_seq_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .shift_en(shift_en), .din(din), .sout(sout),
    .busy(busy), .done(done), .rx_data(rx_data), .mismatch(mismatch)
  );

  // WIDTH=1 / DEPTH=1 instance with a single-flop chain
  logic lv1 = 1'b0, ld1 = 1'b0;
  logic lr1, se1, din1, busy1, done1, mm1, rx1, chain1;
  always @(posedge clk or posedge chain_clr)
    if (chain_clr) chain1 <= 1'b0;
    else if (se1)  chain1 <= din1;

  siso_seq_ctrl #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_ready(lr1),
    .load_data(ld1), .shift_en(se1), .din(din1), .sout(chain1),
    .busy(busy1), .done(done1), .rx_data(rx1), .mismatch(mm1)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] rx;
    logic         mm;
  } exp_t;

  exp_t sb[$];
  int   acc_cyc[$];
  int   cyc = 0;

  function automatic exp_t model(input logic [W-1:0] d, input logic f0);
    exp_t e;
    e.rx = f0 ? '0 : d;
    e.mm = f0 && (d != '0);
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && load_valid && load_ready) begin
      acc_cyc.push_back(cyc);
      sb.push_back(model(load_data, force0));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_rx_data", 32'(rx_data), 32'(e.rx));
        chk("sb_mismatch", 32'(mismatch), 32'(e.mm));
      end
    end
  end

  // Drive one word, then check the per-cycle din/shift_en/done timeline.
  task automatic send_word(input logic [W-1:0] d, input logic f0);
    int t, se_cnt, done_cyc, flush_nz;
    logic [W-1:0] din_got;
    logic lr_after;
    t = 0; se_cnt = 0; done_cyc = 0; flush_nz = 0; din_got = '0; lr_after = 1'b0;
    @(negedge clk);
    force0 = f0; load_valid = 1'b1; load_data = d;
    while (!load_ready && t < 50) begin @(negedge clk); t++; end
    if (!load_ready) begin
      chk("accept_timeout", 32'(load_ready), 32'd1);
      load_valid = 1'b0;
    end else begin
      @(posedge clk); #1 load_valid = 1'b0;
      for (int k = 1; k <= W + D + 2; k++) begin
        @(negedge clk);
        if (k <= W) din_got = {din_got[W-2:0], din};
        if (k > W && k <= W + D && din) flush_nz++;
        if (shift_en) se_cnt++;
        if (done) done_cyc = k;
        if (k == W + D + 2) lr_after = load_ready;
      end
      chk("din_sequence", 32'(din_got), 32'(d));
      chk("flush_din_zero", flush_nz, 0);
      chk("shift_en_cycles", se_cnt, W + D);
      chk("done_cycle", done_cyc, W + D + 1);
      chk("load_ready_after", 32'(lr_after), 32'd1);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         f0;
    logic [W-1:0] exp_rx;
    logic         exp_mm;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int n0, t, dn, se1c, d1c;
    logic din1_first;

    tbl[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
    tbl[1] = '{8'hFF, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'h69, 1'b0, 8'h69, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_shift_en", 32'(shift_en), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0; chain_clr = 1'b0;

    for (int i = 0; i < 4; i++) begin
      send_word(tbl[i].data, tbl[i].f0);
      repeat (3) @(negedge clk);
      chk("tbl_rx_hold", 32'(rx_data), 32'(tbl[i].exp_rx));
      chk("tbl_mm_hold", 32'(mismatch), 32'(tbl[i].exp_mm));
    end
    force0 = 1'b0;

    // back-to-back with load_valid held high
    @(negedge clk);
    n0 = acc_cyc.size();
    load_valid = 1'b1; load_data = 8'h3C;
    t = 0;
    while (acc_cyc.size() <= n0 && t < 40) begin @(negedge clk); t++; end
    load_data = 8'hC3;
    t = 0;
    while (acc_cyc.size() <= n0 + 1 && t < 40) begin @(negedge clk); t++; end
    load_valid = 1'b0;
    if (acc_cyc.size() > n0 + 1)
      chk("b2b_period", acc_cyc[n0+1] - acc_cyc[n0], W + D + 2);
    else
      chk("b2b_accept_timeout", acc_cyc.size(), n0 + 2);
    repeat (16) @(negedge clk);
    chk("b2b_rx_second", 32'(rx_data), 32'hC3);

    // abort during cycle 6 of SHIFT
    @(negedge clk);
    n0 = acc_cyc.size();
    load_valid = 1'b1; load_data = 8'h96;
    t = 0;
    while (acc_cyc.size() <= n0 && t < 40) begin @(negedge clk); t++; end
    load_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_load_ready", 32'(load_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_shift_en", 32'(shift_en), 32'd0);
    chk("abort_din", 32'(din), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    chk("abort_mismatch", 32'(mismatch), 32'd0);
    @(negedge clk); chain_clr = 1'b1;
    @(negedge clk); rst = 1'b0; chain_clr = 1'b0;
    dn = 0;
    repeat (16) begin @(negedge clk); if (done) dn++; end
    chk("abort_no_done", dn, 0);
    send_word(8'h5A, 1'b0);
    chk("after_abort_rx", 32'(rx_data), 32'h5A);

    // WIDTH=1, DEPTH=1
    @(negedge clk);
    lv1 = 1'b1; ld1 = 1'b1;
    t = 0;
    while (!lr1 && t < 10) begin @(negedge clk); t++; end
    @(posedge clk); #1 lv1 = 1'b0;
    se1c = 0; d1c = 0; din1_first = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) din1_first = din1;
      if (se1) se1c++;
      if (done1) begin
        d1c = k;
        chk("w1_rx_data", 32'(rx1), 32'd1);
        chk("w1_mismatch", 32'(mm1), 32'd0);
      end
    end
    chk("w1_din", 32'(din1_first), 32'd1);
    chk("w1_shift_cycles", se1c, 2);
    chk("w1_done_cycle", d1c, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
